// File: rtl/alarm_clk_pkg.sv
// Shared types and constants for the alarm clock blocks.
// Edit-path state encoding and the edit-bus bit indices used across the design.
package alarm_clk_pkg;

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} edit_state_t;

  localparam int EDIT_HR  = 1;
  localparam int EDIT_MIN = 0;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/edit_ctrl.sv
// Edit-button controller: one step per press, then auto-repeat while held.
// Only one button owns the edit path at a time; all outputs are registered.
module edit_ctrl
  import alarm_clk_pkg::*;
#(
  parameter int unsigned HOLD_CYC   = 100_000_000,
  parameter int unsigned REPEAT_CYC = 20_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] btns,
  input  logic       mode,
  output logic [1:0] edit_pulses,
  output logic       busy,
  output logic       repeating
);

  localparam int unsigned CntMax = max_u(HOLD_CYC, REPEAT_CYC);
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;
  localparam logic [CntW-1:0] HoldLast   = CntW'(HOLD_CYC - 1);
  localparam logic [CntW-1:0] RepeatLast = CntW'(REPEAT_CYC - 1);

  edit_state_t     state, state_d;
  logic [1:0]      btns_q, rise, pulse_d;
  logic            mode_q;
  logic            owner, owner_d;
  logic            busy_d, rep_d, abort;
  logic [CntW-1:0] cnt, cnt_d;

  always_comb begin
    rise    = btns & ~btns_q;
    // Release or mode change wins over a terminal count on the same edge.
    abort   = !btns[owner] || (mode != mode_q);
    state_d = state;
    owner_d = owner;
    cnt_d   = cnt;
    pulse_d = '0;
    busy_d  = busy;
    rep_d   = repeating;
    unique case (state)
      IDLE: begin
        if (rise != 2'b00) begin
          owner_d          = rise[EDIT_HR];
          pulse_d[owner_d] = 1'b1;
          cnt_d            = '0;
          state_d          = HOLD;
          busy_d           = 1'b1;
          rep_d            = 1'b0;
        end
      end
      HOLD: begin
        if (abort) begin
          state_d = IDLE;
          cnt_d   = '0;
          busy_d  = 1'b0;
          rep_d   = 1'b0;
        end else if (cnt == HoldLast) begin
          pulse_d[owner] = 1'b1;
          cnt_d          = '0;
          state_d        = REPEAT;
          rep_d          = 1'b1;
        end else begin
          cnt_d = cnt + CntW'(1);
        end
      end
      REPEAT: begin
        if (abort) begin
          state_d = IDLE;
          cnt_d   = '0;
          busy_d  = 1'b0;
          rep_d   = 1'b0;
        end else if (cnt == RepeatLast) begin
          pulse_d[owner] = 1'b1;
          cnt_d          = '0;
        end else begin
          cnt_d = cnt + CntW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        busy_d  = 1'b0;
        rep_d   = 1'b0;
      end
    endcase
  end

  // btns_q resets to all-ones so a button held through reset yields no edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btns_q      <= 2'b11;
      mode_q      <= 1'b0;
      state       <= IDLE;
      owner       <= 1'b0;
      cnt         <= '0;
      edit_pulses <= 2'b00;
      busy        <= 1'b0;
      repeating   <= 1'b0;
    end else begin
      btns_q      <= btns;
      mode_q      <= mode;
      state       <= state_d;
      owner       <= owner_d;
      cnt         <= cnt_d;
      edit_pulses <= pulse_d;
      busy        <= busy_d;
      repeating   <= rep_d;
    end
  end

endmodule

// File: tb/tb_edit_ctrl.sv
// Directed bench for edit_ctrl with HOLD_CYC=10, REPEAT_CYC=4.
// Edge numbers count from 0 after one warm-up edge following reset release.
module tb_edit_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] btns = 2'b00;
  logic       mode = 1'b0;
  logic [1:0] edit_pulses;
  logic       busy;
  logic       repeating;

  int n_cmp = 0;
  int n_err = 0;

  edit_ctrl #(
    .HOLD_CYC  (10),
    .REPEAT_CYC(4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btns       (btns),
    .mode       (mode),
    .edit_pulses(edit_pulses),
    .busy       (busy),
    .repeating  (repeating)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int e, input logic [1:0] obs, input logic [1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s @edge %0d: observed %b expected %b", tag, e, obs, exp);
    end
  endtask

  task automatic step(input logic [1:0] b, input logic m);
    btns = b;
    mode = m;
    @(posedge clk);
    #1;
  endtask

  // Assert reset, check outputs, release mid-cycle, then one warm-up edge.
  task automatic do_reset(input logic [1:0] b);
    btns  = b;
    mode  = 1'b0;
    reset = 1'b1;
    #1;
    chk("rst_pulse", -1, edit_pulses, 2'b00);
    chk("rst_busy", -1, {1'b0, busy}, 2'b00);
    chk("rst_rep", -1, {1'b0, repeating}, 2'b00);
    @(posedge clk);
    @(posedge clk);
    #3;
    reset = 1'b0;
    step(b, 1'b0);
  endtask

  initial begin
    // Minutes held 5..34: pulses at 5,15,19,23,27,31.
    do_reset(2'b00);
    for (int e = 0; e <= 40; e++) begin
      step((e >= 5 && e <= 34) ? 2'b01 : 2'b00, 1'b0);
      chk("s1_pulse", e, edit_pulses,
          (e == 5 || e == 15 || e == 19 || e == 23 || e == 27 || e == 31) ? 2'b01 : 2'b00);
      chk("s1_busy", e, {1'b0, busy}, {1'b0, (e >= 5 && e <= 34)});
      chk("s1_rep", e, {1'b0, repeating}, {1'b0, (e >= 15 && e <= 34)});
    end

    // Both rise at 3: hours wins; minutes needs a fresh press at 20.
    do_reset(2'b00);
    for (int e = 0; e <= 24; e++) begin
      logic [1:0] b;
      if (e >= 3 && e <= 7)        b = 2'b11;
      else if (e >= 8 && e <= 11)  b = 2'b01;
      else if (e >= 20)            b = 2'b01;
      else                         b = 2'b00;
      step(b, 1'b0);
      chk("s2_pulse", e, edit_pulses, (e == 3) ? 2'b10 : (e == 20) ? 2'b01 : 2'b00);
      chk("s2_busy", e, {1'b0, busy}, {1'b0, ((e >= 3 && e <= 7) || e >= 20)});
    end

    // Hours held through reset release: no pulse until the press at 14.
    do_reset(2'b10);
    for (int e = 0; e <= 17; e++) begin
      step((e <= 9 || e >= 14) ? 2'b10 : 2'b00, 1'b0);
      chk("s3_pulse", e, edit_pulses, (e == 14) ? 2'b10 : 2'b00);
    end

    // Mode toggles at 12 while minutes held: edit aborted, no repeat.
    do_reset(2'b00);
    for (int e = 0; e <= 30; e++) begin
      step((e >= 5) ? 2'b01 : 2'b00, (e >= 12) ? 1'b1 : 1'b0);
      chk("s4_pulse", e, edit_pulses, (e == 5) ? 2'b01 : 2'b00);
      chk("s4_busy", e, {1'b0, busy}, {1'b0, (e >= 5 && e <= 11)});
    end

    // Release on the terminal-count edge suppresses the pulse.
    do_reset(2'b00);
    for (int e = 0; e <= 14; e++) begin
      step((e <= 9) ? 2'b01 : 2'b00, 1'b0);
      chk("s5_pulse", e, edit_pulses, (e == 0) ? 2'b01 : 2'b00);
      chk("s5_busy", e, {1'b0, busy}, {1'b0, (e <= 9)});
    end

    // Asynchronous reset while a repeat pulse is high.
    do_reset(2'b00);
    for (int e = 0; e <= 14; e++) begin
      step(2'b01, 1'b0);
      chk("s6_pulse", e, edit_pulses, (e == 0 || e == 10 || e == 14) ? 2'b01 : 2'b00);
      chk("s6_rep", e, {1'b0, repeating}, {1'b0, (e >= 10)});
    end
    #2;
    reset = 1'b1;
    #1;
    chk("s6_async_pulse", 14, edit_pulses, 2'b00);
    chk("s6_async_busy", 14, {1'b0, busy}, 2'b00);
    chk("s6_async_rep", 14, {1'b0, repeating}, 2'b00);
    @(posedge clk);
    @(posedge clk);
    #3;
    reset = 1'b0;
    for (int e = 0; e <= 19; e++) begin
      step(2'b01, 1'b0);
      chk("s6_post_pulse", e, edit_pulses, 2'b00);
      chk("s6_post_busy", e, {1'b0, busy}, 2'b00);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
